// File: rtl/somador_pkg.sv
// Shared types and helpers for the serial add/subtract unit.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package somador_pkg;

  // Control states of the serial adder.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the step counter: enough bits to count STEPS steps,
  // never narrower than one bit so a single-step build still has a counter.
  function automatic int cnt_width(input int steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

endpackage

// File: rtl/somador_digito.sv
// One DIGIT-bit combinational ripple-carry slice of the serial adder.
// Latency: combinational, zero cycles.
// Backpressure: none (pure logic).
// Ports: a, b  - DIGIT-bit operand slices
//        cin   - carry into bit 0
//        s     - DIGIT-bit sum slice
//        cout  - carry out of the top bit
//        c_msb - carry into the top bit (used for signed overflow)
module somador_digito #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  always_comb begin : ripple
    logic c;
    c     = cin;
    s     = '0;
    c_msb = cin;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]  = a[i] ^ b[i] ^ c;
      // After the final iteration this holds the carry entering the top bit.
      c_msb = c;
      c     = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/somador_serial.sv
// Serial add/subtract of two WIDTH-bit operands, DIGIT bits per clock.
// Latency: done pulses STEPS = WIDTH/DIGIT edges after the edge that takes start.
// Backpressure: none; start is ignored while busy, abort cancels an operation.
// Ports: clk, rst_n (async active-low), start/sub/a/b request an operation,
//        abort cancels it; busy (in RUN), done (one-cycle pulse),
//        sum/cout/ovf hold the last completed result.
module somador_serial
  import somador_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int             STEPS = WIDTH / DIGIT;
  localparam int             CW    = cnt_width(STEPS);
  localparam logic [CW-1:0]  LAST  = CW'(STEPS - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0] dig_s;
  logic             dig_co;
  logic             dig_cm;
  logic [WIDTH-1:0] res_shift;

  somador_digito #(
    .DIGIT (DIGIT)
  ) u_digito (
    .a     (a_q[DIGIT-1:0]),
    .b     (b_q[DIGIT-1:0]),
    .cin   (c_q),
    .s     (dig_s),
    .cout  (dig_co),
    .c_msb (dig_cm)
  );

  // New result digits enter at the MSB end, so after STEPS shifts the
  // first (least significant) digit has reached bit 0.
  generate
    if (DIGIT == WIDTH) begin : g_full
      assign res_shift = dig_s;
    end else begin : g_part
      assign res_shift = {dig_s, res_q[WIDTH-1:DIGIT]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (start) begin
          // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
          a_d     = a;
          b_d     = sub ? ~b : b;
          c_d     = sub;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (abort) begin
          // Outputs keep the previous result; only the FSM is cancelled.
          state_d = IDLE;
        end else begin
          a_d   = a_q >> DIGIT;
          b_d   = b_q >> DIGIT;
          res_d = res_shift;
          c_d   = dig_co;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            sum_d   = res_shift;
            cout_d  = dig_co;
            ovf_d   = dig_co ^ dig_cm;
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_somador_serial.sv
// Bench for somador_serial: directed vectors on 8/1 and 8/4 builds,
// random vectors across several WIDTH/DIGIT builds.
// Runs until all stimulus completes, then prints one summary line.
module tb_somador_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Arithmetic reference: unsigned result/carry and signed range overflow.
  function automatic void ref_op(input int w, input int a, input int b, input bit sub,
                                 output int s, output bit c, output bit v);
    int mask, half, t, sa, sb, r;
    mask = (1 << w) - 1;
    half = 1 << (w - 1);
    if (!sub) begin
      t = a + b;
      c = (t >> w) != 0;
    end else begin
      t = a - b;
      c = (a >= b);
    end
    s  = t & mask;
    sa = (a >= half) ? a - (1 << w) : a;
    sb = (b >= half) ? b - (1 << w) : b;
    r  = sub ? sa - sb : sa + sb;
    v  = (r < -half) || (r >= half);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- main 8/1 instance ----------------
  logic       m_rst_n, m_start, m_sub, m_abort;
  logic [7:0] m_a, m_b;
  logic       m_busy, m_done, m_cout, m_ovf;
  logic [7:0] m_sum;

  somador_serial #(.WIDTH(8), .DIGIT(1)) u_dut (
    .clk(clk), .rst_n(m_rst_n), .start(m_start), .sub(m_sub), .abort(m_abort),
    .a(m_a), .b(m_b), .busy(m_busy), .done(m_done), .sum(m_sum),
    .cout(m_cout), .ovf(m_ovf)
  );

  // Behavioural model: edges remaining until completion plus a pending result.
  int rem = 0;
  bit e_done = 0, e_cout = 0, e_ovf = 0, p_cout = 0, p_ovf = 0;
  int e_sum = 0, p_sum = 0;
  bit mon_on = 1;

  always @(posedge clk or negedge m_rst_n) begin
    if (!m_rst_n) begin
      rem = 0; e_done = 0; e_sum = 0; e_cout = 0; e_ovf = 0;
    end else if (rem > 0) begin
      if (m_abort) begin
        rem = 0; e_done = 0;
      end else begin
        rem--;
        e_done = (rem == 0);
        if (rem == 0) begin
          e_sum = p_sum; e_cout = p_cout; e_ovf = p_ovf;
        end
      end
    end else begin
      e_done = 0;
      if (m_start && !m_abort) begin
        ref_op(8, int'(m_a), int'(m_b), m_sub, p_sum, p_cout, p_ovf);
        rem = 8;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      chk("mdl_busy", int'(m_busy), int'(rem > 0));
      chk("mdl_done", int'(m_done), int'(e_done));
      chk("mdl_sum",  int'(m_sum),  e_sum);
      chk("mdl_cout", int'(m_cout), int'(e_cout));
      chk("mdl_ovf",  int'(m_ovf),  int'(e_ovf));
    end
  end

  // Issue one operation from IDLE/DONE and check latency and result literals.
  task automatic op81(input string nm, input int a, input int b, input bit sub,
                      input int xs, input bit xc, input bit xv);
    int lat;
    m_a = 8'(a); m_b = 8'(b); m_sub = sub; m_start = 1'b1;
    tick();
    m_start = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (m_done) begin lat = i; break; end
    end
    chk({nm, "_lat"},  lat, 8);
    chk({nm, "_sum"},  int'(m_sum), xs);
    chk({nm, "_cout"}, int'(m_cout), int'(xc));
    chk({nm, "_ovf"},  int'(m_ovf), int'(xv));
  endtask

  task automatic count_dones(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (m_done) cnt++;
    end
  endtask

  // ---------------- 8/4 instance ----------------
  logic       rst_g;
  logic       q_start, q_sub, q_abort;
  logic [7:0] q_a, q_b;
  logic       q_busy, q_done, q_cout, q_ovf;
  logic [7:0] q_sum;

  somador_serial #(.WIDTH(8), .DIGIT(4)) u_dut4 (
    .clk(clk), .rst_n(rst_g), .start(q_start), .sub(q_sub), .abort(q_abort),
    .a(q_a), .b(q_b), .busy(q_busy), .done(q_done), .sum(q_sum),
    .cout(q_cout), .ovf(q_ovf)
  );

  task automatic op84(input string nm, input int a, input int b, input bit sub,
                      input int xs, input bit xc, input bit xv);
    int lat;
    q_a = 8'(a); q_b = 8'(b); q_sub = sub; q_start = 1'b1;
    tick();
    q_start = 1'b0;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (q_done) begin lat = i; break; end
    end
    chk({nm, "_lat"},  lat, 2);
    chk({nm, "_sum"},  int'(q_sum), xs);
    chk({nm, "_cout"}, int'(q_cout), int'(xc));
    chk({nm, "_ovf"},  int'(q_ovf), int'(xv));
  endtask

  // ---------------- random builds ----------------
  function automatic int cfg_w(input int g);
    case (g)
      0, 1:          return 2;
      2, 3, 4, 5:    return 8;
      default:       return 16;
    endcase
  endfunction

  function automatic int cfg_d(input int g);
    case (g)
      0: return 1;  1: return 2;
      2: return 1;  3: return 2;  4: return 4;  5: return 8;
      6: return 1;  7: return 2;  8: return 4;  9: return 8;
      default: return 16;
    endcase
  endfunction

  localparam int NG = 11;
  int gen_done = 0;

  for (genvar g = 0; g < NG; g++) begin : g_rnd
    localparam int W     = cfg_w(g);
    localparam int D     = cfg_d(g);
    localparam int STEPS = W / D;
    logic         st, sb, ab;
    logic [W-1:0] ra, rb, sm;
    logic         bz, dn, co, ov;

    somador_serial #(.WIDTH(W), .DIGIT(D)) u_r (
      .clk(clk), .rst_n(rst_g), .start(st), .sub(sb), .abort(ab),
      .a(ra), .b(rb), .busy(bz), .done(dn), .sum(sm), .cout(co), .ovf(ov)
    );

    initial begin
      int es, lat;
      bit ec, ev;
      st = 1'b0; sb = 1'b0; ab = 1'b0; ra = '0; rb = '0;
      wait (rst_g === 1'b1);
      for (int n = 0; n < 24; n++) begin
        tick();
        ra = W'($urandom);
        rb = W'($urandom);
        sb = 1'($urandom_range(0, 1));
        if (n == 0) begin ra = '1; rb = '1; sb = 1'b0; end
        if (n == 1) begin ra = '0; rb = '1; sb = 1'b1; end
        ref_op(W, int'(ra), int'(rb), sb, es, ec, ev);
        st = 1'b1;
        tick();
        st = 1'b0;
        lat = 0;
        for (int i = 1; i <= 2 * STEPS + 4; i++) begin
          tick();
          if (dn) begin lat = i; break; end
        end
        chk($sformatf("w%0dd%0d_lat", W, D), lat, STEPS);
        chk($sformatf("w%0dd%0d_sum", W, D), int'(sm), es);
        chk($sformatf("w%0dd%0d_cout", W, D), int'(co), int'(ec));
        chk($sformatf("w%0dd%0d_ovf", W, D), int'(ov), int'(ev));
      end
      gen_done++;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int lat, gap, cnt;
    bit found;
    m_rst_n = 1'b0; rst_g = 1'b0;
    m_start = 0; m_sub = 0; m_abort = 0; m_a = '0; m_b = '0;
    q_start = 0; q_sub = 0; q_abort = 0; q_a = '0; q_b = '0;
    #2;
    chk("rst_busy", int'(m_busy), 0);
    chk("rst_done", int'(m_done), 0);
    chk("rst_sum",  int'(m_sum),  0);
    chk("rst_cout", int'(m_cout), 0);
    chk("rst_ovf",  int'(m_ovf),  0);
    tick(); tick();
    m_rst_n = 1'b1; rst_g = 1'b1;

    op81("add_100_27",  100, 27,  0, 127,  0, 0);
    op81("add_200_100", 200, 100, 0, 44,   1, 0);
    op81("add_100_50",  100, 50,  0, 8'h96, 0, 1);
    op81("sub_5_7",     5,   7,   1, 8'hFE, 0, 0);
    op81("sub_80_1",    8'h80, 1, 1, 8'h7F, 1, 1);
    op81("sub_0_0",     0,   0,   1, 0,    1, 0);

    op84("d4_sub_5_7",  5, 7, 1, 8'hFE, 0, 0);
    op84("d4_sub_80_1", 8'h80, 1, 1, 8'h7F, 1, 1);

    // start held high across DONE: back-to-back with no idle gap
    m_a = 10; m_b = 20; m_sub = 0; m_start = 1'b1;
    tick();
    m_a = 3; m_b = 4;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (m_done) begin lat = i; break; end
    end
    chk("hold_lat1", lat, 8);
    chk("hold_sum1", int'(m_sum), 30);
    tick();
    m_start = 1'b0;
    gap = 1; found = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      gap++;
      if (m_done) begin found = 1; break; end
    end
    if (!found) gap = 0;
    chk("hold_gap", gap, 9);
    chk("hold_sum2", int'(m_sum), 7);

    // start pulses during RUN are ignored
    m_a = 1; m_b = 1; m_sub = 0; m_start = 1'b1;
    tick();
    m_start = 1'b0;
    tick(); tick(); tick();
    m_start = 1'b1; m_a = 200; m_b = 200;
    tick();
    m_start = 1'b0;
    tick();
    m_start = 1'b1; m_sub = 1'b1;
    tick();
    m_start = 1'b0;
    lat = 0;
    for (int k = 7; k <= 20; k++) begin
      tick();
      if (m_done) begin lat = k; break; end
    end
    chk("runstart_lat", lat, 8);
    chk("runstart_sum", int'(m_sum), 2);
    chk("runstart_cout", int'(m_cout), 0);

    // abort at step 3 keeps the prior result and gives no done
    m_a = 9; m_b = 9; m_sub = 0; m_start = 1'b1;
    tick();
    m_start = 1'b0;
    tick(); tick(); tick();
    m_abort = 1'b1;
    tick();
    m_abort = 1'b0;
    chk("abort_busy", int'(m_busy), 0);
    chk("abort_done", int'(m_done), 0);
    chk("abort_sum",  int'(m_sum),  2);
    count_dones(12, cnt);
    chk("abort_no_done", cnt, 0);

    // abort beats start in IDLE and in DONE
    m_start = 1'b1; m_abort = 1'b1;
    tick();
    chk("abort_idle_busy", int'(m_busy), 0);
    m_start = 1'b0; m_abort = 1'b0;
    op81("add_1_2", 1, 2, 0, 3, 0, 0);
    m_start = 1'b1; m_abort = 1'b1; m_a = 50; m_b = 50;
    tick();
    chk("abort_done_busy", int'(m_busy), 0);
    chk("abort_done_done", int'(m_done), 0);
    chk("abort_done_sum",  int'(m_sum),  3);
    m_start = 1'b0; m_abort = 1'b0;

    // asynchronous reset at step 5
    m_a = 50; m_b = 60; m_sub = 0; m_start = 1'b1;
    tick();
    m_start = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    #2 m_rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(m_busy), 0);
    chk("arst_done", int'(m_done), 0);
    chk("arst_sum",  int'(m_sum),  0);
    chk("arst_cout", int'(m_cout), 0);
    chk("arst_ovf",  int'(m_ovf),  0);
    tick(); tick();
    m_rst_n = 1'b1;
    count_dones(12, cnt);
    chk("arst_no_done", cnt, 0);

    // start accepted on the first edge after reset release
    m_rst_n = 1'b0;
    tick();
    m_rst_n = 1'b1;
    op81("post_rst_7_8", 7, 8, 0, 15, 0, 0);

    for (int i = 0; i < 5000 && gen_done < NG; i++) @(posedge clk);
    chk("gen_all_done", gen_done, NG);
    mon_on = 0;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/somador_serial.md
SOMADOR_SERIAL -- requirements
Module: somador_serial

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits, SHALL be >= 2.
REQ-002 Parameter DIGIT, default 1, bits added per clock; SHALL divide WIDTH exactly. STEPS = WIDTH/DIGIT.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request a new operation, sampled on rising edge.
REQ-006 sub  input  1  0 = A+B, 1 = A-B; sampled with start.
REQ-007 abort  input  1  cancel the operation in progress.
REQ-008 a, b  input  WIDTH each  operands; sampled with start.
REQ-009 busy  output  1  high while in RUN.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 sum  output  WIDTH  result, registered.
REQ-012 cout  output  1  carry out (add) / no-borrow (sub).
REQ-013 ovf  output  1  two's-complement signed overflow.

Function
REQ-014 Three states SHALL exist: IDLE, RUN, DONE.
REQ-015 In IDLE or DONE, start=1 SHALL be accepted:
- latch a into shift register A
- latch b, or ~b when sub=1, into shift register B
- carry register <= sub
- step counter <= 0
- state <= RUN
REQ-016 In RUN, each edge SHALL add the DIGIT LSBs of A and B plus carry, shift the DIGIT result bits into the MSB end of a result shift register, shift A and B right by DIGIT, update carry, and increment the step counter.
REQ-017 On the edge completing step STEPS-1, the block SHALL load sum from the result register, cout from the final carry, and ovf from (carry into MSB) XOR (carry out of MSB); state <= DONE.
REQ-018 done SHALL be high exactly the one cycle in DONE, beginning STEPS edges after the edge that sampled start.
REQ-019 From DONE, the next state SHALL be RUN if start=1, otherwise IDLE, so back-to-back operations run with no idle gap.
REQ-020 start while in RUN SHALL be ignored; it SHALL NOT corrupt the operation in progress.
REQ-021 abort=1 in RUN SHALL return to IDLE on the next edge with no done pulse; sum, cout and ovf SHALL keep their previous values.
REQ-022 abort has priority over start in every state; abort in IDLE or DONE SHALL force IDLE.
REQ-023 sum, cout and ovf SHALL hold their values from completion until the next completion.
REQ-024 Arithmetic SHALL be modulo 2^WIDTH; no width extension on sum.

Reset
REQ-025 rst_n=0 SHALL immediately, regardless of clk:
- force state IDLE
- clear busy, done, sum, cout, ovf, carry, step counter and all shift registers to 0
REQ-026 Reset asserted mid-RUN SHALL discard the operation; after release no done pulse SHALL occur until a new start.
REQ-027 The first edge after rst_n rises SHALL be able to accept start.

Structure
REQ-028 Package somador_pkg SHALL hold the state enumeration (IDLE, RUN, DONE) and a constant function computing the step counter width, $clog2(STEPS) with a minimum of 1.
REQ-029 The datapath slice SHALL be one sub-module, somador_digito: a DIGIT-bit combinational ripple adder with inputs a, b, cin and outputs s, cout, c_msb (carry into its top bit).
REQ-030 The top module SHALL own the FSM, shift registers, counter and output registers; no other sub-modules.

Verification
REQ-031 WIDTH=8, DIGIT=1: a=100, b=27, sub=0 -> done 8 edges after start, sum=127, cout=0, ovf=0.
REQ-032 WIDTH=8, DIGIT=1: a=200, b=100, sub=0 -> sum=44, cout=1, ovf=0. Same with a=100, b=50 -> sum=0x96, cout=0, ovf=1.
REQ-033 WIDTH=8, DIGIT=4: a=5, b=7, sub=1 -> done 2 edges after start, sum=0xFE, cout=0, ovf=0. a=0x80, b=1, sub=1 -> sum=0x7F, cout=1, ovf=1.
REQ-034 start held high across DONE -> second result's done exactly STEPS+1 edges after the first done; start pulses during RUN change nothing.
REQ-035 abort at step 3 of 8 -> IDLE next edge, no done, sum keeps the prior result. rst_n low at step 5 -> all outputs 0 asynchronously, no later done.
REQ-036 Random a, b, sub over WIDTH in {2, 8, 16} and all valid DIGIT -> sum, cout and ovf match a reference model on every done.
